// File: rtl/nn_pkg.sv
// nn_pkg: shared types and constants for the fully connected
// layer sequencer and its MAC/accumulator datapath.
package nn_pkg;

  localparam int DW_D         = 16;
  localparam int ACCW_D       = 32;
  localparam int LUT_AW_D     = 8;
  localparam int BIAS_ALIGN   = 8;
  localparam int IDX_SHIFT    = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_BIAS,
    S_ADD,
    S_ACT,
    S_CAPT,
    S_EMIT,
    S_DONE
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/nn_mac_acc.sv
// nn_mac_acc: signed MAC with one-cycle data alignment, bias add
// and accumulator-to-sigmoid-index clamp.
module nn_mac_acc
  import nn_pkg::*;
#(
  parameter int DW         = DW_D,
  parameter int ACCW       = ACCW_D,
  parameter int LUT_AW     = LUT_AW_D,
  parameter int SHIFT      = IDX_SHIFT,
  parameter int ALIGN      = BIAS_ALIGN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mac_en_i,
  input  logic              add_en_i,
  input  logic              clr_i,
  input  logic [DW-1:0]     a_i,
  input  logic [DW-1:0]     b_i,
  input  logic [DW-1:0]     bias_i,
  output logic [LUT_AW-1:0] idx_o
);

  localparam int LIM = 2 ** (LUT_AW - 1);
  localparam logic signed [ACCW-1:0] TMAX = ACCW'(LIM - 1);
  localparam logic signed [ACCW-1:0] TMIN = ACCW'(-LIM);

  logic                   mac_vld_q;
  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] acc_d;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] bias_al;
  logic signed [ACCW-1:0] t;

  assign prod    = $signed(a_i) * $signed(b_i);
  assign bias_al = ACCW'($signed(bias_i)) <<< ALIGN;

  // Memory data lags its address by a cycle, so MAC enables
  // are delayed one cycle before accumulating.
  always_comb begin
    acc_d = acc_q;
    if (clr_i)
      acc_d = '0;
    else if (mac_vld_q)
      acc_d = acc_q + ACCW'(prod);
    else if (add_en_i)
      acc_d = acc_q + bias_al;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mac_vld_q <= 1'b0;
      acc_q     <= '0;
    end else begin
      mac_vld_q <= mac_en_i;
      acc_q     <= acc_d;
    end
  end

  assign t = acc_q >>> SHIFT;

  always_comb begin
    idx_o = '0;
    if (t > TMAX)
      idx_o = '1;
    else if (t < TMIN)
      idx_o = '0;
    else
      idx_o = {~t[LUT_AW-1], t[LUT_AW-2:0]};
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: steps one shared MAC through a fully
// connected layer and streams activations over valid/ready.
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int N_IN      = 10,
  parameter int N_OUT     = 10,
  parameter int DW        = DW_D,
  parameter int ACCW      = ACCW_D,
  parameter int LUT_AW    = LUT_AW_D,
  parameter int IDX_SHIFT = nn_pkg::IDX_SHIFT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [clog2(N_IN)-1:0]         in_addr_o,
  input  logic [DW-1:0]                  in_data_i,
  output logic [clog2(N_IN*N_OUT)-1:0]   w_addr_o,
  input  logic [DW-1:0]                  w_data_i,
  output logic [clog2(N_OUT)-1:0]        b_addr_o,
  input  logic [DW-1:0]                  b_data_i,
  output logic [LUT_AW-1:0]              lut_addr_o,
  input  logic [DW-1:0]                  lut_data_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [clog2(N_OUT)-1:0]        out_idx_o,
  output logic [DW-1:0]                  out_data_o
);

  localparam int IW = clog2(N_IN);
  localparam int WW = clog2(N_IN * N_OUT);
  localparam int OW = clog2(N_OUT);

  state_e            state_q, state_d;
  logic [IW-1:0]     j_q, j_d;
  logic [OW-1:0]     i_q, i_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              vld_q, vld_d;
  logic [IW-1:0]     in_addr_q, in_addr_d;
  logic [WW-1:0]     w_addr_q, w_addr_d;
  logic [OW-1:0]     b_addr_q, b_addr_d;
  logic [LUT_AW-1:0] lut_q, lut_d;
  logic [OW-1:0]     oidx_q, oidx_d;
  logic [DW-1:0]     odata_q, odata_d;
  logic              acc_clr;
  logic [LUT_AW-1:0] lut_idx;

  function automatic logic [WW-1:0] waddr(
    input logic [OW-1:0] i,
    input logic [IW-1:0] j
  );
    return WW'(int'(i) * N_IN + int'(j));
  endfunction

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    vld_d     = vld_q;
    in_addr_d = in_addr_q;
    w_addr_d  = w_addr_q;
    b_addr_d  = b_addr_q;
    lut_d     = lut_q;
    oidx_d    = oidx_q;
    odata_d   = odata_q;
    acc_clr   = 1'b0;
    unique case (state_q)
      S_IDLE: if (start_i) begin
        state_d   = S_MAC;
        i_d       = '0;
        j_d       = '0;
        busy_d    = 1'b1;
        acc_clr   = 1'b1;
        in_addr_d = '0;
        w_addr_d  = waddr('0, '0);
      end
      S_MAC: if (j_q == IW'(N_IN - 1)) begin
        state_d  = S_BIAS;
        b_addr_d = i_q;
      end else begin
        j_d       = j_q + 1'b1;
        in_addr_d = j_q + 1'b1;
        w_addr_d  = waddr(i_q, j_q + 1'b1);
      end
      S_BIAS: state_d = S_ADD;
      S_ADD:  state_d = S_ACT;
      S_ACT: begin
        state_d = S_CAPT;
        lut_d   = lut_idx;
      end
      S_CAPT: begin
        state_d = S_EMIT;
        vld_d   = 1'b1;
        odata_d = lut_data_i;
        oidx_d  = i_q;
      end
      S_EMIT: if (out_ready_i) begin
        vld_d   = 1'b0;
        acc_clr = 1'b1;
        if (i_q == OW'(N_OUT - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d   = S_MAC;
          i_d       = i_q + 1'b1;
          j_d       = '0;
          in_addr_d = '0;
          w_addr_d  = waddr(i_q + 1'b1, '0);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vld_q     <= 1'b0;
      in_addr_q <= '0;
      w_addr_q  <= '0;
      b_addr_q  <= '0;
      lut_q     <= '0;
      oidx_q    <= '0;
      odata_q   <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      vld_q     <= vld_d;
      in_addr_q <= in_addr_d;
      w_addr_q  <= w_addr_d;
      b_addr_q  <= b_addr_d;
      lut_q     <= lut_d;
      oidx_q    <= oidx_d;
      odata_q   <= odata_d;
    end
  end

  nn_mac_acc #(
    .DW     (DW),
    .ACCW   (ACCW),
    .LUT_AW (LUT_AW),
    .SHIFT  (IDX_SHIFT),
    .ALIGN  (BIAS_ALIGN)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .mac_en_i (state_q == S_MAC),
    .add_en_i (state_q == S_ADD),
    .clr_i    (acc_clr),
    .a_i      (in_data_i),
    .b_i      (w_data_i),
    .bias_i   (b_data_i),
    .idx_o    (lut_idx)
  );

  // The LUT index is presented during ACT so its data lands in CAPT.
  assign lut_addr_o  = (state_q == S_ACT) ? lut_idx : lut_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign in_addr_o   = in_addr_q;
  assign w_addr_o    = w_addr_q;
  assign b_addr_o    = b_addr_q;
  assign out_valid_o = vld_q;
  assign out_idx_o   = oidx_q;
  assign out_data_o  = odata_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: table-driven layer runs with a queue
// scoreboard, plus stall, restart and reset corner sequences.
module tb_nn_layer_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, busy, done;
  logic [3:0]  in_addr, b_addr, out_idx;
  logic [6:0]  w_addr;
  logic [7:0]  lut_addr;
  logic [15:0] in_data, w_data, b_data, lut_data, out_data;
  logic        out_valid, out_ready;

  always #5 clk = ~clk;

  nn_layer_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .in_addr_o   (in_addr),
    .in_data_i   (in_data),
    .w_addr_o    (w_addr),
    .w_data_i    (w_data),
    .b_addr_o    (b_addr),
    .b_data_i    (b_data),
    .lut_addr_o  (lut_addr),
    .lut_data_i  (lut_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_idx_o   (out_idx),
    .out_data_o  (out_data)
  );

  logic [15:0] in_mem [10];
  logic [15:0] w_mem  [100];
  logic [15:0] b_mem  [10];

  always @(posedge clk) begin
    in_data  <= in_mem[int'(in_addr)];
    w_data   <= w_mem[int'(w_addr)];
    b_data   <= b_mem[int'(b_addr)];
    lut_data <= {~lut_addr, lut_addr};
  end

  typedef struct {
    logic [15:0] x;
    logic [15:0] w;
    logic [15:0] b;
    logic [7:0]  lut;
  } vec_t;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] data;
  } exp_t;

  vec_t vt [8];
  exp_t sbq [$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_mem(input logic [15:0] x, input logic [15:0] w,
                         input logic [15:0] b);
    for (int n = 0; n < 10; n++) begin
      in_mem[n] = x;
      b_mem[n]  = b;
    end
    for (int n = 0; n < 100; n++) w_mem[n] = w;
  endtask

  task automatic push_exp(input logic [7:0] lut);
    exp_t e;
    for (int n = 0; n < 10; n++) begin
      e.idx  = 4'(n);
      e.data = {~lut, lut};
      sbq.push_back(e);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_odata"}, 32'(out_data), 0);
    chk({tag, "_oidx"}, 32'(out_idx), 0);
    chk({tag, "_addrs"},
        32'({in_addr, w_addr, b_addr, lut_addr}), 0);
  endtask

  task automatic run_layer(input int stall_n, input int glitch_k,
                           input bit chained, input bit chk_addr,
                           input int exp_done);
    int k = 0;
    int first = -1;
    int done_at = -1;
    int scnt = 0;
    int addr_bad = 0;
    int stab_bad = 0;
    int p;
    logic [30:0] snap;
    exp_t e;
    if (!chained) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (done_at < 0 && k < 3000) begin
      @(negedge clk);
      k++;
      start = (k == glitch_k);
      if (k == 1) chk("busy_run", 32'(busy), 1);
      p = k - 1;
      if (chk_addr && p / 15 < 10 && p % 15 < 10) begin
        if (w_addr !== 7'((p / 15) * 10 + p % 15) ||
            in_addr !== 4'(p % 15))
          addr_bad++;
      end
      if (out_valid && first < 0) first = p;
      if (out_valid && int'(out_idx) == stall_n && scnt < 5) begin
        if (scnt == 0)
          snap = {out_data, in_addr, w_addr, out_idx};
        else if (snap !== {out_data, in_addr, w_addr, out_idx})
          stab_bad++;
        scnt++;
        out_ready = 1'b0;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected", 32'(out_idx), 32'hFFFF);
        end else begin
          e = sbq.pop_front();
          chk("out_idx", 32'(out_idx), 32'(e.idx));
          chk("out_data", 32'(out_data), 32'(e.data));
        end
      end
      if (done) done_at = p;
    end
    chk("done_seen", 32'(done_at >= 0), 1);
    chk("first_valid", 32'(first), 14);
    chk("done_edge", 32'(done_at), 32'(exp_done));
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("busy_after", 32'(busy), 0);
    chk("sb_drain", 32'(sbq.size()), 0);
    if (chk_addr) chk("w_addr_seq", 32'(addr_bad), 0);
    if (stall_n >= 0) begin
      chk("stall_len", 32'(scnt), 5);
      chk("stall_stable", 32'(stab_bad), 0);
    end
  endtask

  int ndone;

  initial begin
    vt[0] = '{16'h1234, 16'h0000, 16'h0000, 8'd128};
    vt[1] = '{16'h0100, 16'h0100, 16'h0000, 8'd138};
    vt[2] = '{16'h7FFF, 16'h7FFF, 16'h0000, 8'd255};
    vt[3] = '{16'h7FFF, 16'h8000, 16'h0000, 8'd0};
    vt[4] = '{16'h0000, 16'h0000, 16'h0200, 8'd130};
    vt[5] = '{16'h0100, 16'hFF00, 16'h0100, 8'd119};
    vt[6] = '{16'h0080, 16'h0300, 16'hFF80, 8'd142};
    vt[7] = '{16'h0080, 16'hFF00, 16'h0040, 8'd123};

    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    set_mem(16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    chk_zero("rst");
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      set_mem(vt[v].x, vt[v].w, vt[v].b);
      push_exp(vt[v].lut);
      run_layer(-1, (v == 2) ? 30 : 0, v == 3, v == 1, 150);
    end

    // Consumer stalls five cycles on neuron 3.
    set_mem(vt[1].x, vt[1].w, vt[1].b);
    push_exp(vt[1].lut);
    run_layer(3, 0, 1'b0, 1'b0, 155);

    // Reset during MAC of neuron 4 abandons the run.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (65) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (200) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("no_done_after_rst", 32'(ndone), 0);

    set_mem(vt[5].x, vt[5].w, vt[5].b);
    push_exp(vt[5].lut);
    run_layer(-1, 0, 1'b0, 1'b1, 150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
